sudoku_game_ctrl: RTL and testbench

Single-clock, parametrised successor to the two-phase Sudoku main controller. It sequences board setup, difficulty selection and cell/value entry. It validates user inputs against the board size and holds a req/done handshake with the checker datapath. It also counts mistakes toward a LOSE state, supports a "back" step, and restarts from the terminal states. It sits between the user input debouncers and the board datapath/checker.

---
 rtl/sudoku_game_ctrl.sv | 135 +++++++++++++
 tb/tb_sudoku_game_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sudoku_game_ctrl.sv
// sudoku_game_ctrl: game sequencer for setup, move entry, checker handshake and win/lose tracking
module sudoku_game_ctrl #(
  parameter int N             = 9,
  parameter int IDX_W         = 4,
  parameter int DIFF_LEVELS   = 3,
  parameter int MAX_MISTAKES  = 3,
  parameter int MISS_W        = 2,
  parameter int CHECK_TIMEOUT = 16
) (
  input  logic              clka,
  input  logic              restart_n,
  input  logic              enter,
  input  logic              back,
  input  logic [IDX_W-1:0]  user_in,
  input  logic              check_done,
  input  logic              check_ok,
  input  logic              solved,
  output logic [3:0]        state,
  output logic              gen_rand_flag,
  output logic              set_board_flag,
  output logic              set_diff_flag,
  output logic              row_flag,
  output logic              col_flag,
  output logic              val_flag,
  output logic [IDX_W-1:0]  diff_reg,
  output logic [IDX_W-1:0]  row_reg,
  output logic [IDX_W-1:0]  col_reg,
  output logic [IDX_W-1:0]  val_reg,
  output logic              check_req,
  output logic              write_en,
  output logic              invalid_input,
  output logic [MISS_W-1:0] mistakes,
  output logic              win,
  output logic              lose
);
  localparam logic [3:0] S_IDLE = 4'd0, S_BOARD = 4'd1, S_DIFF = 4'd2, S_ROW = 4'd3, S_COL = 4'd4,
                         S_VAL = 4'd5, S_CHECK = 4'd6, S_WAIT = 4'd7, S_WIN = 4'd8, S_LOSE = 4'd9;
  localparam int TW = $clog2(CHECK_TIMEOUT);
  localparam logic [IDX_W-1:0]  N_V    = IDX_W'(N);
  localparam logic [IDX_W-1:0]  DIFF_V = IDX_W'(DIFF_LEVELS);
  localparam logic [MISS_W-1:0] MAX_V  = MISS_W'(MAX_MISTAKES);
  localparam logic [TW-1:0]     TO_V   = TW'(CHECK_TIMEOUT - 1);
  logic enter_q, back_q, enter_p, back_p, diff_ok, idx_ok, val_ok, timeout, reject;
  logic write_en_d, invalid_d;
  logic [3:0] state_d;
  logic [TW-1:0] timer, timer_d;
  logic [IDX_W-1:0] diff_d, row_d, col_d, val_d;
  logic [MISS_W-1:0] miss_inc, mistakes_d;
  assign enter_p  = enter & ~enter_q;
  assign back_p   = back & ~back_q;
  assign diff_ok  = user_in < DIFF_V;
  assign idx_ok   = user_in < N_V;
  assign val_ok   = (user_in != '0) && (user_in <= N_V);
  assign timeout  = timer == TO_V;
  assign reject   = (state == S_CHECK) && check_done && !check_ok;
  assign miss_inc = (mistakes >= MAX_V) ? mistakes : mistakes + 1'b1;
  // state and registered outputs; flags decode the next state so they track state exactly
  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      state          <= S_IDLE;
      gen_rand_flag  <= 1'b1;
      set_board_flag <= 1'b0;
      set_diff_flag  <= 1'b0;
      row_flag       <= 1'b0;
      col_flag       <= 1'b0;
      val_flag       <= 1'b0;
      check_req      <= 1'b0;
      win            <= 1'b0;
      lose           <= 1'b0;
      write_en       <= 1'b0;
      invalid_input  <= 1'b0;
      diff_reg       <= '0;
      row_reg        <= '0;
      col_reg        <= '0;
      val_reg        <= '0;
      mistakes       <= '0;
      timer          <= '0;
      enter_q        <= 1'b0;
      back_q         <= 1'b0;
    end else begin
      state          <= state_d;
      gen_rand_flag  <= state_d == S_IDLE;
      set_board_flag <= state_d == S_BOARD;
      set_diff_flag  <= state_d == S_DIFF;
      row_flag       <= state_d == S_ROW;
      col_flag       <= state_d == S_COL;
      val_flag       <= state_d == S_VAL;
      check_req      <= state_d == S_CHECK;
      win            <= state_d == S_WIN;
      lose           <= state_d == S_LOSE;
      write_en       <= write_en_d;
      invalid_input  <= invalid_d;
      diff_reg       <= diff_d;
      row_reg        <= row_d;
      col_reg        <= col_d;
      val_reg        <= val_d;
      mistakes       <= mistakes_d;
      timer          <= timer_d;
      enter_q        <= enter;
      back_q         <= back;
    end
  end
  // next-state: back_p takes priority wherever it is honoured
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  state_d = enter_p ? S_BOARD : state;
      S_BOARD: state_d = enter_p ? S_DIFF : state;
      S_DIFF:  state_d = (enter_p && diff_ok) ? S_ROW : state;
      S_ROW:   state_d = (enter_p && idx_ok) ? S_COL : state;
      S_COL:   state_d = back_p ? S_ROW : (enter_p && idx_ok) ? S_VAL : state;
      S_VAL:   state_d = back_p ? S_COL : (enter_p && val_ok) ? S_CHECK : state;
      S_CHECK: state_d = check_done ? (check_ok ? S_WAIT : (miss_inc >= MAX_V ? S_LOSE : S_ROW))
                                    : (timeout ? S_ROW : state);
      S_WAIT:  state_d = solved ? S_WIN : S_ROW;
      S_WIN, S_LOSE: state_d = enter_p ? S_IDLE : state;
      default: state_d = S_IDLE;
    endcase
  end
  // captured fields, mistake count, pulses and check timer
  always_comb begin
    diff_d     = (state == S_IDLE) ? '0 : (state == S_DIFF && enter_p && diff_ok) ? user_in : diff_reg;
    row_d      = (state == S_IDLE) ? '0 : (state == S_ROW && enter_p && idx_ok) ? user_in : row_reg;
    col_d      = (state == S_IDLE) ? '0 : (state == S_COL && enter_p && !back_p && idx_ok) ? user_in : col_reg;
    val_d      = (state == S_IDLE) ? '0 : (state == S_VAL && enter_p && !back_p && val_ok) ? user_in : val_reg;
    mistakes_d = (state == S_IDLE) ? '0 : reject ? miss_inc : mistakes;
    write_en_d = (state == S_CHECK) && check_done && check_ok;
    invalid_d  = ((state == S_DIFF) && enter_p && !diff_ok) ||
                 ((state == S_ROW) && enter_p && !idx_ok) ||
                 ((state == S_COL) && enter_p && !back_p && !idx_ok) ||
                 ((state == S_VAL) && enter_p && !back_p && !val_ok) ||
                 ((state == S_CHECK) && !check_done && timeout);
    timer_d    = (state == S_CHECK) ? timer + 1'b1 : '0;
  end
endmodule

// File: tb/tb_sudoku_game_ctrl.sv
// tb_sudoku_game_ctrl: scoreboard bench for the sudoku game controller
module tb_sudoku_game_ctrl;
  typedef struct {int r; int c; int v;} mv_t;
  logic clka = 1'b0, restart_n, enter, back, check_done, check_ok, solved;
  logic [3:0] user_in, state, diff_reg, row_reg, col_reg, val_reg;
  logic gen_rand_flag, set_board_flag, set_diff_flag, row_flag, col_flag, val_flag;
  logic check_req, write_en, invalid_input, win, lose;
  logic [1:0] mistakes;
  int checks = 0, errors = 0, s_state, s_inv, n;
  mv_t wq[$];
  string inv_q[$];
  mv_t m;

  sudoku_game_ctrl dut (
    .clka(clka), .restart_n(restart_n), .enter(enter), .back(back), .user_in(user_in),
    .check_done(check_done), .check_ok(check_ok), .solved(solved), .state(state),
    .gen_rand_flag(gen_rand_flag), .set_board_flag(set_board_flag), .set_diff_flag(set_diff_flag),
    .row_flag(row_flag), .col_flag(col_flag), .val_flag(val_flag), .diff_reg(diff_reg),
    .row_reg(row_reg), .col_reg(col_reg), .val_reg(val_reg), .check_req(check_req),
    .write_en(write_en), .invalid_input(invalid_input), .mistakes(mistakes), .win(win), .lose(lose)
  );

  always #5 clka = ~clka;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic press(input int v, input bit e, input bit b);
    user_in = 4'(v);
    enter = e;
    back = b;
    tick();
    s_state = state;
    s_inv = invalid_input;
    enter = 1'b0;
    back = 1'b0;
    tick();
  endtask

  task automatic move(input int r, input int c, input int v);
    press(r, 1, 0);
    press(c, 1, 0);
    press(v, 1, 0);
    chk("move_to_check", s_state, 6);
  endtask

  // commit scoreboard and invalid-pulse scoreboard
  always @(negedge clka) begin
    if (write_en) begin
      if (wq.size() == 0) chk("wen_extra", 1, 0);
      else begin
        m = wq.pop_front();
        chk("wen_row", row_reg, m.r);
        chk("wen_col", col_reg, m.c);
        chk("wen_val", val_reg, m.v);
      end
    end
    if (invalid_input) begin
      if (inv_q.size() == 0) chk("inv_extra", 1, 0);
      else void'(inv_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    restart_n = 1'b0; enter = 1'b0; back = 1'b0; user_in = '0;
    check_done = 1'b0; check_ok = 1'b0; solved = 1'b0;
    repeat (2) tick();
    chk("rst_state", state, 0);
    chk("rst_gen_rand", gen_rand_flag, 1);
    chk("rst_set_board", set_board_flag, 0);
    chk("rst_check_req", check_req, 0);
    chk("rst_mistakes", mistakes, 0);
    restart_n = 1'b1;
    tick();
    enter = 1'b1;
    repeat (10) tick();
    chk("hold_state", state, 1);
    chk("hold_gen_rand", gen_rand_flag, 0);
    chk("hold_set_board", set_board_flag, 1);
    enter = 1'b0;
    tick();
    press(0, 1, 0);
    chk("board_to_diff", s_state, 2);
    chk("diff_flag", set_diff_flag, 1);
    inv_q.push_back("diff3");
    press(3, 1, 0);
    chk("diff_bad_state", s_state, 2);
    chk("diff_bad_inv", s_inv, 1);
    chk("diff_bad_reg", diff_reg, 0);
    press(1, 1, 0);
    chk("diff_ok_state", s_state, 3);
    chk("diff_reg", diff_reg, 1);
    chk("row_flag", row_flag, 1);
    inv_q.push_back("row9");
    press(9, 1, 0);
    chk("row_bad_state", s_state, 3);
    chk("row_bad_inv", s_inv, 1);
    chk("row_bad_reg", row_reg, 0);
    press(4, 1, 0);
    chk("row_ok_state", s_state, 4);
    press(7, 1, 0);
    chk("col_ok_state", s_state, 5);
    chk("col_reg", col_reg, 7);
    inv_q.push_back("val0");
    press(0, 1, 0);
    chk("val_bad_state", s_state, 5);
    chk("val_bad_inv", s_inv, 1);
    chk("val_bad_reg", val_reg, 0);
    press(0, 0, 1);
    chk("back_val_col", s_state, 4);
    press(0, 0, 1);
    chk("back_col_row", s_state, 3);
    chk("back_row_kept", row_reg, 4);
    press(4, 1, 0);
    press(5, 1, 1);
    chk("both_state", s_state, 3);
    chk("both_inv", s_inv, 0);
    chk("both_col_kept", col_reg, 7);
    press(4, 1, 0);
    press(7, 1, 0);
    wq.push_back('{4, 7, 9});
    press(9, 1, 0);
    chk("enter_check", s_state, 6);
    chk("check_req", check_req, 1);
    chk("val_reg", val_reg, 9);
    tick();
    check_done = 1'b1; check_ok = 1'b1; solved = 1'b1;
    tick();
    chk("ok_wait", state, 7);
    chk("ok_wen", write_en, 1);
    check_done = 1'b0; check_ok = 1'b0;
    tick();
    chk("win_state", state, 8);
    chk("win_flag", win, 1);
    chk("wen_once", write_en, 0);
    solved = 1'b0;
    press(0, 0, 1);
    chk("win_back_ign", s_state, 8);
    press(0, 1, 0);
    chk("win_restart", s_state, 0);
    chk("idle_row_clr", row_reg, 0);
    chk("idle_gen_rand", gen_rand_flag, 1);
    press(0, 1, 0);
    press(0, 1, 0);
    press(2, 1, 0);
    for (int k = 1; k <= 3; k++) begin
      move(k, k + 1, k + 2);
      check_done = 1'b1; check_ok = 1'b0;
      tick();
      check_done = 1'b0;
      chk("rej_mistakes", mistakes, k);
      chk("rej_state", state, k < 3 ? 3 : 9);
    end
    chk("lose_flag", lose, 1);
    press(0, 1, 0);
    chk("lose_restart", s_state, 0);
    chk("lose_mistakes_clr", mistakes, 0);
    chk("lose_clr", lose, 0);
    press(0, 1, 0);
    press(0, 1, 0);
    press(0, 1, 0);
    move(2, 3, 5);
    check_done = 1'b1; check_ok = 1'b0;
    tick();
    check_done = 1'b0;
    chk("to_pre_mistakes", mistakes, 1);
    move(2, 3, 5);
    inv_q.push_back("timeout");
    n = 1;
    while (state == 4'd6 && n < 40) begin
      tick();
      n++;
    end
    chk("to_cycles", n, 16);
    chk("to_state", state, 3);
    chk("to_inv", invalid_input, 1);
    chk("to_mistakes", mistakes, 1);
    move(6, 7, 8);
    repeat (14) tick();
    chk("edge_pre", state, 6);
    check_done = 1'b1; check_ok = 1'b1;
    wq.push_back('{6, 7, 8});
    tick();
    chk("edge_done_state", state, 7);
    chk("edge_done_inv", invalid_input, 0);
    check_done = 1'b0; check_ok = 1'b0;
    tick();
    chk("wait_unsolved", state, 3);
    move(1, 1, 1);
    chk("mid_check_req", check_req, 1);
    restart_n = 1'b0;
    #1;
    chk("arst_check_req", check_req, 0);
    chk("arst_state", state, 0);
    chk("arst_gen_rand", gen_rand_flag, 1);
    chk("arst_mistakes", mistakes, 0);
    check_done = 1'b1; check_ok = 1'b1;
    tick();
    check_done = 1'b0; check_ok = 1'b0;
    restart_n = 1'b1;
    tick();
    chk("post_rst_state", state, 0);
    chk("post_rst_wen", write_en, 0);
    tick();
    chk("wen_pending", wq.size(), 0);
    chk("inv_pending", inv_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
